// File: rtl/dot_product_pkg.sv
// Shared definitions for dot_product_sched: scheduler state encoding, datapath widths
// and the batch-count helper.
package dot_product_pkg;
  localparam int DATA_W = 32;
  localparam int RES_W  = 64;

  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, RESP} state_t;

  function automatic int batches(input int n, input int unroll);
    return n / unroll;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, returns a one-hot grant,
// its encoded index and whether any request was found.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);

  always_comb begin
    int c;
    logic [IW-1:0] pos;
    c     = 0;
    pos   = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NREQ) c = c - NREQ;
      pos = IW'(c);
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dot_product_sched.sv
// Round-robin job scheduler feeding one shared dot-product engine from operand memories.
// Optional watchdog on the engine-done wait is enabled by defining SCHED_WATCHDOG_EN.
module dot_product_sched
  import dot_product_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int N      = 1024,
  parameter int UNROLL = 4,
  parameter int AW     = 10
`ifdef SCHED_WATCHDOG_EN
  , parameter int TIMEOUT = 100
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*AW-1:0]         req_base_a,
  input  logic [NREQ*AW-1:0]         req_base_b,
  output logic                       mem_rd_en,
  output logic [AW-1:0]              mem_addr_a,
  output logic [AW-1:0]              mem_addr_b,
  input  logic [UNROLL*DATA_W-1:0]   mem_rdata_a,
  input  logic [UNROLL*DATA_W-1:0]   mem_rdata_b,
  output logic                       eng_start,
  output logic                       eng_valid,
  output logic [UNROLL*DATA_W-1:0]   eng_data_a,
  output logic [UNROLL*DATA_W-1:0]   eng_data_b,
  input  logic                       eng_done,
  input  logic [RES_W-1:0]           eng_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [RES_W-1:0]           rsp_result,
  output logic                       rsp_err
);
  localparam int BATCHES = batches(N, UNROLL);
  localparam int KW      = $clog2(BATCHES + 1);
  localparam int IW      = $clog2(NREQ);

  state_t            state_reg, state_next;
  logic [IW-1:0]     ptr_reg, gid_reg;
  logic [AW-1:0]     base_a_reg, base_b_reg;
  logic [KW-1:0]     k_reg;
  logic [RES_W-1:0]  result_reg;
  logic              eng_valid_reg;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic              accept, last_k, wd_expire;
  logic [AW-1:0]     base_a_arr [NREQ];
  logic [AW-1:0]     base_b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign base_a_arr[gi] = req_base_a[gi*AW +: AW];
      assign base_b_arr[gi] = req_base_b[gi*AW +: AW];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign accept = |(req_valid & req_ready);
  // k runs one step past the last read so the final beat drains before WAIT
  assign last_k = (k_reg == KW'(BATCHES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = START;
      START:   state_next = STREAM;
      STREAM:  if (last_k) state_next = WAIT;
      WAIT:    if (eng_done || wd_expire) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    mem_rd_en = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:    if (!rst) req_ready = grant;
      START:   eng_start = 1'b1;
      STREAM:  mem_rd_en = !last_k;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= '0;
      gid_reg       <= '0;
      base_a_reg    <= '0;
      base_b_reg    <= '0;
      k_reg         <= '0;
      result_reg    <= '0;
      eng_valid_reg <= 1'b0;
    end else begin
      eng_valid_reg <= mem_rd_en;
      case (state_reg)
        IDLE: if (accept) begin
          base_a_reg <= base_a_arr[grant_idx];
          base_b_reg <= base_b_arr[grant_idx];
          gid_reg    <= grant_idx;
        end
        START:  k_reg <= '0;
        STREAM: if (!last_k) k_reg <= k_reg + KW'(1);
        WAIT: begin
          if (eng_done)       result_reg <= eng_result;
          else if (wd_expire) result_reg <= '0;
        end
        RESP: if (rsp_ready) ptr_reg <= (gid_reg == IW'(NREQ - 1)) ? '0 : gid_reg + IW'(1);
        default: ;
      endcase
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt_reg;
  logic           err_reg;

  assign wd_expire = (state_reg == WAIT) && (wd_cnt_reg == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == WAIT) ? wd_cnt_reg + WDW'(1) : '0;
      if (state_reg == START)                         err_reg <= 1'b0;
      else if (state_reg == WAIT && !eng_done && wd_expire) err_reg <= 1'b1;
    end
  end
  assign rsp_err = err_reg;
`else
  assign wd_expire = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign mem_addr_a = base_a_reg + AW'(k_reg);
  assign mem_addr_b = base_b_reg + AW'(k_reg);
  assign eng_valid  = eng_valid_reg;
  assign eng_data_a = eng_valid_reg ? mem_rdata_a : '0;
  assign eng_data_b = eng_valid_reg ? mem_rdata_b : '0;
  assign rsp_id     = gid_reg;
  assign rsp_result = result_reg;
endmodule

// File: tb/tb_dot_product_sched.sv
// Scoreboard bench for dot_product_sched with behavioural operand memories and engine.
module tb_dot_product_sched;
  import dot_product_pkg::*;

  localparam int NREQ = 4, N = 1024, UNROLL = 4, AW = 10;
  localparam int BATCHES = N / UNROLL;
  localparam int IW = $clog2(NREQ);
  localparam int DEPTH = 1 << AW;
  localparam int WB = UNROLL * DATA_W;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*AW-1:0] req_base_a, req_base_b;
  logic mem_rd_en;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [WB-1:0] mem_rdata_a = '0, mem_rdata_b = '0;
  logic eng_start, eng_valid;
  logic [WB-1:0] eng_data_a, eng_data_b;
  logic eng_done = 1'b0;
  logic [RES_W-1:0] eng_result = '0;
  logic rsp_valid, rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [RES_W-1:0] rsp_result;
  logic rsp_err;

  always #5 clk = ~clk;

  dot_product_sched #(.NREQ(NREQ), .N(N), .UNROLL(UNROLL), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_a(req_base_a), .req_base_b(req_base_b),
    .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
    .eng_start(eng_start), .eng_valid(eng_valid),
    .eng_data_a(eng_data_a), .eng_data_b(eng_data_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic [IW-1:0]    id;
    logic [RES_W-1:0] result;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int tests_run = 0, tests_failed = 0;
  logic [WB-1:0] mem_a [DEPTH];
  logic [WB-1:0] mem_b [DEPTH];

  int cyc = 0, start_cnt = 0, beat_cnt = 0, rdy0_cnt = 0;
  int grant_cyc = 0, rsp_lat = 0;
  bit rsp_valid_q = 0, wrap_seen = 0, have_prev = 0, eng_hang = 0;
  logic [AW-1:0] prev_addr_a = '0;
  int done_lat = 1;
  longint acc = 0;
  int beats = 0, dly = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint beat_sum(input logic [WB-1:0] a, input logic [WB-1:0] b);
    longint s = 0;
    for (int j = 0; j < UNROLL; j++)
      s += longint'($signed(a[j*DATA_W +: DATA_W])) * longint'($signed(b[j*DATA_W +: DATA_W]));
    return s;
  endfunction

  function automatic longint golden(input int ba, input int bb);
    longint s = 0;
    for (int k = 0; k < BATCHES; k++)
      s += beat_sum(mem_a[(ba + k) % DEPTH], mem_b[(bb + k) % DEPTH]);
    return s;
  endfunction

  // operand memories, one-cycle read latency
  initial forever begin
    @(posedge clk);
    if (mem_rd_en) begin
      mem_rdata_a <= mem_a[mem_addr_a];
      mem_rdata_b <= mem_b[mem_addr_b];
    end
  end

  // engine: accumulates beats, raises a level done done_lat cycles after the last beat
  initial forever begin
    @(posedge clk);
    if (eng_start) begin
      acc <= 0; beats <= 0; dly <= 0; eng_done <= 1'b0;
    end else if (eng_valid) begin
      acc   <= acc + beat_sum(eng_data_a, eng_data_b);
      beats <= beats + 1;
      if (beats + 1 == BATCHES && !eng_hang) begin
        if (done_lat == 1) begin
          eng_done <= 1'b1; eng_result <= acc + beat_sum(eng_data_a, eng_data_b);
        end else dly <= done_lat;
      end
    end else if (dly == 2) begin
      eng_done <= 1'b1; eng_result <= acc; dly <= 0;
    end else if (dly > 2) dly <= dly - 1;
  end

  // monitor and scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (eng_start) start_cnt++;
      if (eng_valid) beat_cnt++;
      if (req_ready[0]) rdy0_cnt++;
      if (mem_rd_en) begin
        if (have_prev && prev_addr_a == AW'(DEPTH - 1) && mem_addr_a == '0) wrap_seen = 1;
        prev_addr_a = mem_addr_a;
        have_prev = 1;
      end
      if (|(req_valid & req_ready)) grant_cyc = cyc;
      if (rsp_valid && !rsp_valid_q) rsp_lat = cyc - grant_cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          $display("[TB] rsp id=%0d result=%0d err=%0d", rsp_id, $signed(rsp_result), rsp_err);
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_result", rsp_result, e.result);
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
      rsp_valid_q = rsp_valid;
    end
  end

  task automatic issue(input int id, input int ba, input int bb, input logic [63:0] res, input logic err);
    exp_t e;
    e.id = IW'(id); e.result = res; e.err = err;
    sb_q.push_back(e);
    req_base_a[id*AW +: AW] = AW'(ba);
    req_base_b[id*AW +: AW] = AW'(bb);
    req_valid[id] = 1'b1;
    $display("[TB] req id=%0d base_a=%0d base_b=%0d", id, ba, bb);
  endtask

  task automatic wait_grant(input int id);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req_ready[id] && req_valid[id]) begin
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        return;
      end
    end
    check($sformatf("grant_timeout_%0d", id), 64'd0, 64'd1);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      if (sb_q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic clear_counts();
    start_cnt = 0; beat_cnt = 0; rdy0_cnt = 0; wrap_seen = 0; have_prev = 0;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++)
      for (int j = 0; j < UNROLL; j++) begin
        if (a < 256) begin
          mem_a[a][j*DATA_W +: DATA_W] = 32'd1;
          mem_b[a][j*DATA_W +: DATA_W] = 32'(a*UNROLL + j + 1);
        end else if (a < 512) begin
          mem_a[a][j*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
          mem_b[a][j*DATA_W +: DATA_W] = 32'd2;
        end else begin
          mem_a[a][j*DATA_W +: DATA_W] = 32'(int'($urandom_range(0, 2000)) - 1000);
          mem_b[a][j*DATA_W +: DATA_W] = 32'(int'($urandom_range(0, 2000)) - 1000);
        end
      end

    rst = 1'b1; req_valid = '1; req_base_a = '0; req_base_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_eng_start", 64'(eng_start), 64'd0);
    check("reset_eng_valid", 64'(eng_valid), 64'd0);
    check("reset_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // single job from requester 0
    clear_counts();
    issue(0, 0, 0, 64'd524800, 1'b0);
    wait_grant(0);
    drain();
    check("start_pulses", 64'(start_cnt), 64'd1);
    check("valid_beats", 64'(beat_cnt), 64'(BATCHES));
    check("ready0_pulses", 64'(rdy0_cnt), 64'd1);
    check("latency", 64'(rsp_lat), 64'(BATCHES + 1 + 3));

    // negative operands, requester 3, slower engine
    done_lat = 4;
    issue(3, 256, 256, 64'(-2048), 1'b0);
    wait_grant(3);
    drain();

    // fairness: 0 and 2 together at pointer 0, then 0 again behind 2
    issue(0, 512, 600, golden(512, 600), 1'b0);
    issue(2, 700, 800, golden(700, 800), 1'b0);
    wait_grant(0);
    issue(0, 300, 900, golden(300, 900), 1'b0);
    wait_grant(2);
    wait_grant(0);
    drain();

    // response back-pressure
    rsp_ready = 1'b0;
    issue(1, 100, 50, golden(100, 50), 1'b0);
    wait_grant(1);
    for (int c = 0; c < 2000 && !rsp_valid; c++) @(negedge clk);
    issue(2, 520, 530, golden(520, 530), 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
      check("hold_rsp_result", rsp_result, sb_q[0].result);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_grant(2);
    drain();

    // address wrap-around on A
    clear_counts();
    issue(1, DEPTH - 8, 20, golden(DEPTH - 8, 20), 1'b0);
    wait_grant(1);
    drain();
    check("addr_wrap", 64'(wrap_seen), 64'd1);

    // reset mid-stream
    clear_counts();
    issue(2, 40, 60, golden(40, 60), 1'b0);
    wait_grant(2);
    for (int c = 0; c < 500 && beat_cnt < 100; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("midrst_eng_valid", 64'(eng_valid), 64'd0);
    check("midrst_eng_start", 64'(eng_start), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    // pointer must be back at 0, so 1 wins over 3
    issue(1, 10, 900, golden(10, 900), 1'b0);
    issue(3, 610, 10, golden(610, 10), 1'b0);
    wait_grant(1);
    wait_grant(3);
    drain();

`ifdef SCHED_WATCHDOG_EN
    eng_hang = 1;
    issue(0, 0, 0, 64'd0, 1'b1);
    wait_grant(0);
    drain();
    eng_hang = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dot_product_sched.md
Name: dot_product_sched

Overview:
- Round-robin job scheduler sharing one dot_product_unroll engine between NREQ requesters.
- Each request carries two batch-aligned base addresses into operand memories A and B.
- Scheduler grants one requester, pulses engine start and streams N/UNROLL batches from memory into the engine.
- It then captures the engine result and returns it tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..16).
- N, 1024, vector length in elements; must equal the engine's N.
- UNROLL, 4, element pairs per batch; N divisible by UNROLL.
- AW, 10, memory address width in batch units.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  one-hot grant; handshake completes on req_valid[i]&req_ready[i].
- req_base_a  in  NREQ*AW  packed A base addresses, requester i at bits [i*AW +: AW].
- req_base_b  in  NREQ*AW  packed B base addresses.
- mem_rd_en  out  1  read strobe for both memories.
- mem_addr_a  out  AW  A batch address.
- mem_addr_b  out  AW  B batch address.
- mem_rdata_a  in  UNROLL*32  A words, element j at [j*32 +: 32]; 1-cycle read latency.
- mem_rdata_b  in  UNROLL*32  B words, same layout.
- eng_start  out  1  engine start pulse.
- eng_valid  out  1  batch valid to engine.
- eng_data_a  out  UNROLL*32  batch A operands, signed.
- eng_data_b  out  UNROLL*32  batch B operands, signed.
- eng_done  in  1  engine done, level or pulse.
- eng_result  in  64  engine signed result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NREQ)  id of the requester served.
- rsp_result  out  64  captured signed result.
- rsp_err  out  1  watchdog error flag.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; round-robin pointer goes to 0.
  - All outputs are 0, including req_ready, eng_start, eng_valid, mem_rd_en, rsp_valid and rsp_err.
  - The engine is not separately reset; the next job's eng_start reinitialises it.
- States and timing:
  - IDLE:
    - Round-robin search from the pointer over req_valid.
    - If any request is found at cycle T, req_ready[g] is high during T only (combinational from req_valid and pointer).
    - Latch base_a, base_b and g; go to START.
  - START: eng_start=1 for exactly one cycle (T+1); batch counter k is cleared; go to STREAM.
  - STREAM:
    - mem_rd_en=1 for BATCHES=N/UNROLL consecutive cycles (T+2..T+1+BATCHES).
    - mem_addr_a = base_a+k and mem_addr_b = base_b+k, both modulo 2^AW (wrap-around permitted).
    - eng_valid is mem_rd_en delayed one cycle.
    - eng_data_a/b are driven directly from mem_rdata_a/b, so eng_valid is high on T+3..T+2+BATCHES.
    - Go to WAIT after the last valid beat.
  - WAIT:
    - eng_done is ignored before the last beat.
    - On the first cycle eng_done=1, capture eng_result and go to RESP.
  - RESP:
    - rsp_valid=1; rsp_id and rsp_result are held stable until rsp_ready.
    - On rsp_valid&rsp_ready go to IDLE; pointer = g+1 mod NREQ.
    - No new grant is issued in the same cycle.
- Only one job is in flight; requests arriving outside IDLE wait with req_ready=0.
- req_valid dropping before grant is legal (no grant issued).
- No arithmetic on data; operands pass through unmodified.
- Minimum job latency from grant to rsp_valid is BATCHES + engine done latency + 3 cycles.

Optional Feature:
- SCHED_WATCHDOG_EN, with parameter TIMEOUT default 100 cycles.
- Defined:
  - A WAIT-state counter runs.
  - If eng_done is not seen within TIMEOUT cycles, go to RESP with rsp_err=1 and rsp_result=0.
  - rsp_err is 0 on normal completion.
- Undefined: no counter; WAIT is unbounded; rsp_err is tied 0.

Decomposition:
- dot_product_pkg holds:
  - State encoding (IDLE, START, STREAM, WAIT, RESP).
  - DATA_W=32 and RES_W=64.
  - A BATCHES helper function.
- Sub-module rr_arbiter (NREQ, one-hot grant plus encoded index, pointer input) is natural and reusable.

Test Plan:
- Single request, requester 0: A=all 1, B=1..1024.
  - req_ready[0] pulses once; eng_start single pulse; exactly 256 eng_valid beats.
  - Response: rsp_id=0, rsp_result=524800.
- Negative data, requester 3: A=all -1, B=all 2 -> rsp_result=-2048, rsp_id=3.
- Requesters 0 and 2 asserted together with pointer 0 -> grant order 0 then 2; a re-asserted 0 is served after 2.
- rsp_ready held low 5 cycles -> rsp_valid, rsp_id and rsp_result stay stable; req_ready stays 0 throughout.
- base_a = 2^AW-8 -> mem_addr_a wraps from 1023 to 0; result matches the wrapped-operand golden value.
- Reset asserted mid-STREAM (batch 100):
  - Outputs go to 0 immediately.
  - A fresh request afterwards completes correctly.
  - With SCHED_WATCHDOG_EN and eng_done held 0, rsp_err=1 after 100 WAIT cycles.
